// File: rtl/seed_tree_reconstruct.sv
// Verifier-side seed-tree reconstruction: rebuilds every leaf seed except the hidden one
// from the revealed co-path seeds, time-sharing one external node hash engine.
module seed_tree_reconstruct #(
    parameter int DEPTH  = 4,
    parameter int SEED_W = 128
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [DEPTH-1:0]              i_hidden_idx,
    input  logic [DEPTH*SEED_W-1:0]       i_rev_seed,
    input  logic [255:0]                  i_salt,
    input  logic [7:0]                    i_t,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [(2**DEPTH)*SEED_W-1:0]  o_leaves,
    output logic [(2**DEPTH)-1:0]         o_leaf_mask,
    output logic                          o_hash_start,
    output logic [511:0]                  o_hash_msg,
    input  logic                          i_hash_done,
    input  logic [2*SEED_W-1:0]           i_hash_digest
);
    localparam int NLEAF = 1 << DEPTH;
    localparam int NINT  = NLEAF - 1;
    localparam int NNODE = 2 * NLEAF - 1;
    localparam int IW    = DEPTH + 1;
    localparam logic [IW-1:0] LAST_N = IW'(NINT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HREQ, S_HWAIT, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IW-1:0]           r_n, w_n_nxt;
    logic [SEED_W-1:0]       r_node [NNODE];
    logic [SEED_W-1:0]       w_node_nxt [NNODE];
    logic [NNODE-1:0]        r_known, w_known_nxt;
    logic [DEPTH-1:0]        r_hidden;
    logic [255:0]            r_salt;
    logic [7:0]              r_t;
    logic [NLEAF*SEED_W-1:0] r_leaves, w_leaves;
    logic [NLEAF-1:0]        r_mask;
    logic                    w_capture, w_finish;
    logic [IW-1:0]           w_c1, w_c2, w_x, w_sib;

    assign w_c1 = {r_n[IW-2:0], 1'b1};
    assign w_c2 = w_c1 + IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_node_nxt  = r_node;
        w_known_nxt = r_known;
        w_capture   = 1'b0;
        w_x         = '0;
        w_sib       = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_capture   = 1'b1;
                    w_known_nxt = '0;
                    w_node_nxt  = '{default: '0};
                    // Walk from the hidden leaf towards the root; slice 0 is the leaf-level sibling.
                    w_x = IW'(NINT) + {1'b0, i_hidden_idx};
                    for (int lvl = 0; lvl < DEPTH; lvl++) begin
                        w_sib = w_x[0] ? w_x + IW'(1) : w_x - IW'(1);
                        w_known_nxt[w_sib] = 1'b1;
                        w_node_nxt[w_sib]  = i_rev_seed[lvl*SEED_W +: SEED_W];
                        w_x = (w_x - IW'(1)) >> 1;
                    end
                    w_n_nxt     = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_known[r_n])
                    w_state_nxt = S_HREQ;
                else if (r_n == LAST_N)
                    w_state_nxt = S_DONE;
                else
                    w_n_nxt = r_n + IW'(1);
            end
            S_HREQ: w_state_nxt = S_HWAIT;
            S_HWAIT: begin
                if (i_hash_done) begin
                    w_node_nxt[w_c1]  = i_hash_digest[2*SEED_W-1:SEED_W];
                    w_node_nxt[w_c2]  = i_hash_digest[SEED_W-1:0];
                    w_known_nxt[w_c1] = 1'b1;
                    w_known_nxt[w_c2] = 1'b1;
                    if (r_n == LAST_N) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_n_nxt     = r_n + IW'(1);
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_finish = (w_state_nxt == S_DONE);

    // Leaves are taken from the next-state array so the final digest lands in the same DONE cycle.
    always_comb begin
        w_leaves = '0;
        for (int k = 0; k < NLEAF; k++)
            w_leaves[(NLEAF-1-k)*SEED_W +: SEED_W] =
                w_known_nxt[NINT+k] ? w_node_nxt[NINT+k] : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_node   <= '{default: '0};
            r_known  <= '0;
            r_hidden <= '0;
            r_salt   <= '0;
            r_t      <= '0;
            r_leaves <= '0;
            r_mask   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_node  <= w_node_nxt;
            r_known <= w_known_nxt;
            if (w_capture) begin
                r_hidden <= i_hidden_idx;
                r_salt   <= i_salt;
                r_t      <= i_t;
            end
            if (w_finish) begin
                r_leaves <= w_leaves;
                r_mask   <= ~(NLEAF'(1) << r_hidden);
            end
        end
    end

    assign o_busy       = (r_state == S_SCAN) || (r_state == S_HREQ) || (r_state == S_HWAIT);
    assign o_done       = (r_state == S_DONE);
    assign o_hash_start = (r_state == S_HREQ);
    assign o_hash_msg   = {8'h01, r_node[r_n], r_salt, r_t, 8'(r_n), 8'h80, 32'h0, 64'h198};
    assign o_leaves     = r_leaves;
    assign o_leaf_mask  = r_mask;

endmodule

// File: tb/tb_seed_tree_reconstruct.sv
// Scoreboard bench for seed_tree_reconstruct: a behavioural hash engine answers requests,
// a monitor checks each done against the expectation queued when the start was issued.
module tb_seed_tree_reconstruct;
    localparam int D = 4, SW = 128, NL = 16, NI = 15, NN = 31;
    localparam logic [127:0] ROOT = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [255:0] SALT = 256'hA5A5_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0_1357_9BDF_2468;
    localparam logic [7:0]   TREP = 8'd3;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [D-1:0]    hid = '0;
    logic [D*SW-1:0] rev = '0;
    logic [255:0]    salt = SALT;
    logic [7:0]      t = TREP;
    logic            busy, done, hs;
    logic            eng_done = 1'b0, stray = 1'b0, hdone;
    logic [NL*SW-1:0] leaves;
    logic [NL-1:0]   mask;
    logic [511:0]    msg;
    logic [255:0]    digest = '0;

    assign hdone = eng_done | stray;

    seed_tree_reconstruct #(.DEPTH(D), .SEED_W(SW)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_hidden_idx(hid), .i_rev_seed(rev),
        .i_salt(salt), .i_t(t), .o_busy(busy), .o_done(done), .o_leaves(leaves),
        .o_leaf_mask(mask), .o_hash_start(hs), .o_hash_msg(msg), .i_hash_done(hdone),
        .i_hash_digest(digest));

    always #5 clk = ~clk;

    typedef struct {
        logic [NL*SW-1:0] leaves;
        logic [NL-1:0]    mask;
        int               lat;
        int               start_cyc;
    } exp_t;
    typedef struct {
        logic [127:0] seed;
        logic [7:0]   n;
    } mexp_t;

    exp_t  sb[$];
    mexp_t mq[$];
    logic [127:0] tree [NN];
    logic [NL*SW-1:0] prev_leaves = '0;
    logic [511:0] first_msg = '0;
    bit   first_pending = 1'b0;
    int   n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, hcount = 0, eng_L = 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [255:0] fake_hash(input logic [511:0] m);
        logic [127:0] a, b, c, d, h1, h2;
        a = m[511:384]; b = m[383:256]; c = m[255:128]; d = m[127:0];
        h1 = a + (b ^ {c[100:0], c[127:101]}) + {d[63:0], d[127:64]};
        h2 = (a ^ {b[90:0], b[127:91]}) + c + (d ^ 128'h9E3779B97F4A7C15F39CC0605CEDC834);
        return {h1, h2};
    endfunction

    function automatic logic [511:0] build_msg(input logic [127:0] seed, input logic [7:0] n);
        return {8'h01, seed, SALT, TREP, n, 8'h80, 32'h0, 64'h198};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // hash engine: answers eng_L cycles after the request
    initial begin
        logic [511:0] cap;
        mexp_t m;
        forever begin
            @(negedge clk);
            if (hs && !rst) begin
                cap = msg;
                if (first_pending) begin
                    first_msg = cap;
                    first_pending = 1'b0;
                end
                if (mq.size() == 0) flag("unexpected_hash_start");
                else begin
                    m = mq.pop_front();
                    chk("hash_msg", cap, build_msg(m.seed, m.n));
                end
                repeat (eng_L) @(negedge clk);
                if (busy) chk("hash_msg_stable", msg, cap);
                digest = fake_hash(cap);
                eng_done = 1'b1;
                @(negedge clk);
                eng_done = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) hcount = 0;
            else begin
                if (hs) hcount++;
                if (done) begin
                    done_cnt++;
                    if (sb.size() == 0) flag("unexpected_done");
                    else begin
                        e = sb.pop_front();
                        for (int k = 0; k < NL; k++)
                            chk($sformatf("leaf%0d", k), leaves[(NL-1-k)*SW +: SW], e.leaves[(NL-1-k)*SW +: SW]);
                        chk("leaf_mask", mask, e.mask);
                        chk("hash_count", hcount, 11);
                        chk("latency", cyc - e.start_cyc, e.lat);
                        chk("busy_at_done", busy, 1'b0);
                    end
                    hcount = 0;
                end
            end
        end
    end

    task automatic gen_tree();
        logic [255:0] dg;
        tree[0] = ROOT;
        for (int n = 0; n < NI; n++) begin
            dg = fake_hash(build_msg(tree[n], 8'(n)));
            tree[2*n+1] = dg[255:128];
            tree[2*n+2] = dg[127:0];
        end
    endtask

    // drive inputs for hidden leaf h; optionally queue expectations
    task automatic setup(input int h, input int L, input logic [NL-1:0] hand_mask, input bit push);
        int x, sib;
        bit [NN-1:0] kn;
        exp_t e;
        kn = '0;
        x = NI + h;
        for (int lvl = 0; lvl < D; lvl++) begin
            sib = (x % 2 == 1) ? x + 1 : x - 1;
            rev[lvl*SW +: SW] = tree[sib];
            kn[sib] = 1'b1;
            x = (x - 1) / 2;
        end
        hid = 4'(h);
        eng_L = L;
        if (push) begin
            for (int n = 0; n < NI; n++)
                if (kn[n]) begin
                    kn[2*n+1] = 1'b1;
                    kn[2*n+2] = 1'b1;
                    mq.push_back('{tree[n], 8'(n)});
                end
            for (int k = 0; k < NL; k++)
                e.leaves[(NL-1-k)*SW +: SW] = (k == h) ? 128'h0 : tree[NI+k];
            e.mask = hand_mask;
            e.lat = 1 + 15 + 11 * (1 + L);
            e.start_cyc = cyc;
            sb.push_back(e);
            prev_leaves = e.leaves;
            first_pending = 1'b1;
        end
    endtask

    task automatic wait_done(input string nm);
        int b;
        bit got;
        b = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done_cnt != b) got = 1'b1;
        end
        if (!got) flag({nm, "_timeout"});
    endtask

    task automatic run(input int h, input int L, input logic [NL-1:0] hand_mask, input string nm);
        @(negedge clk);
        setup(h, L, hand_mask, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm);
    endtask

    initial begin
        gen_tree();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hash_start", hs, 1'b0);
        chk("rst_leaves_zero", leaves == '0, 1'b1);
        chk("rst_mask", mask, 16'h0);
        rst = 1'b0;

        run(5, 2, 16'hFFDF, "golden_h5");
        run(0, 1, 16'hFFFE, "h0");
        chk("h0_first_node", first_msg[111:104], 8'h02);
        run(15, 1, 16'h7FFF, "h15");
        chk("h15_first_node", first_msg[111:104], 8'h01);

        run(5, 3, 16'hFFDF, "lat_L3");
        chk("msg_prefix", first_msg[511:504], 8'h01);
        chk("msg_seed", first_msg[503:376], tree[2]);
        chk("msg_salt", first_msg[375:120], SALT);
        chk("msg_t", first_msg[119:112], 8'h03);
        chk("msg_node", first_msg[111:104], 8'h02);
        chk("msg_pad", first_msg[103:0], {8'h80, 32'h0, 64'h198});

        // stray hash_done in IDLE must not disturb anything
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        @(negedge clk);
        chk("idle_stray_busy", busy, 1'b0);
        chk("idle_stray_mask", mask, 16'hFFDF);
        chk("idle_stray_leaves", leaves == prev_leaves, 1'b1);

        // stray hash_done in SCAN, then start while busy
        @(negedge clk);
        setup(15, 1, 16'h7FFF, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        hid = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_midrun", busy, 1'b1);
        chk("mask_held_midrun", mask, 16'hFFDF);
        chk("leaf5_held_midrun", leaves[(NL-1-5)*SW +: SW], 128'h0);
        wait_done("busy_start");

        // reset during HWAIT, engine answers afterwards
        @(negedge clk);
        setup(5, 3, 16'hFFDF, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (hs) seen = 1'b1;
            end
            if (!seen) flag("hash_start_timeout");
        end
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        mq.delete();
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_hash_start", hs, 1'b0);
        chk("mid_rst_leaves_zero", leaves == '0, 1'b1);
        chk("mid_rst_mask", mask, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_mask", mask, 16'h0);
        chk("post_rst_leaves_zero", leaves == '0, 1'b1);

        run(5, 2, 16'hFFDF, "golden_after_rst");
        repeat (3) @(negedge clk);
        if (sb.size() != 0) flag("scoreboard_not_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
